mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control FSM for the MIPS-subset datapath (reg_file, alu, dmem, sign extender, muxes). Replaces the single-cycle opcode decoder so one ALU and one unified instruction/data memory port are reused across cycles. Sequences fetch, decode, execute, memory and writeback, and handshakes with a memory that may insert wait states.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles per memory access before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  load instruction register
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- pc_src  out  2  00 ALU result, 01 ALU-out register (branch target), 10 jump address
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU-out register, 1 = memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  unsupported opcode/funct pulse
- mem_err  out  1  memory timeout pulse
- state  out  4  current state (debug)

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
- Outputs are decoded from registered state. Unlisted outputs are 0. alu_control defaults to 010.
- RST: all outputs 0. Always -> FETCH next cycle.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00. ir_write and pc_write equal mem_ready. Stays until mem_ready, then -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target precompute). Next state by opcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 001000 -> ADDI_EX; 000100 -> BRANCH; 000010 -> JUMP. Any other opcode: illegal=1, -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. -> ALUWB. Unknown funct: alu_control=010, illegal=1, -> FETCH, no writeback.
- ALUWB: reg_dst=1, reg_write=1. -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10. -> ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, branch=1, pc_src=01. -> FETCH.
- JUMP: pc_src=10, pc_write=1. -> FETCH.
- Timeout: a wait counter clears on entry to any mem_req state and increments each cycle that mem_req=1 and mem_ready=0. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with ready still low: mem_err=1 for one cycle, -> FETCH. The access is abandoned and no ir_write/reg_write follows. A FETCH timeout re-fetches from the unchanged PC.

## Timing
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready-low cycle adds one.
- mem_req holds until the cycle mem_ready=1. It deasserts the following cycle unless the next state also requests.
- mem_ready outside mem_req states is ignored.
- ir_write and pc_en in FETCH are high only in the ready cycle: exactly one PC increment per instruction.
- pc_en in BRANCH is combinational on zero, same cycle.
- rst low: state=RST and all outputs 0 immediately (asynchronous), including mid-access. Leaving reset: RST for one cycle, then FETCH.
- illegal and mem_err are single-cycle pulses. Reset value 0.

## Test plan
- Reset mid-MEMRD with mem_ready low -> mem_req drops to 0 asynchronously. After release: RST, then FETCH, mem_req=1, iord=0.
- add (opcode 0, funct 100000), zero wait -> FETCH, DECODE, EXEC (alu_control=010), ALUWB (reg_write=1, reg_dst=1). pc_en high once.
- lw with 3 wait cycles in MEMRD -> mem_req high 4 cycles, then MEMWB with mem_to_reg=1, reg_write=1. Total 8 cycles.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH. With zero=0 -> pc_en=0. Both return to FETCH.
- opcode 111111 -> illegal pulse in DECODE, no reg_write or mem_req, next state FETCH. funct 111111 -> illegal pulse in EXEC, no ALUWB.
- MEM_TIMEOUT=4, mem_ready held low in MEMWR -> mem_err pulse after 4 wait cycles, -> FETCH, no reg_write.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller
//
// Multi-cycle control FSM for the MIPS-subset datapath. One ALU and one
// unified instruction/data memory port are shared across the fetch, decode,
// execute, memory and writeback cycles of each instruction.
//
// Memory handshake: mem_req is held high for the whole access. The access
// completes in the cycle where mem_req=1 and mem_ready=1. mem_ready is ignored
// in states that do not request. With MEM_TIMEOUT != 0, an access that has
// already waited MEM_TIMEOUT cycles and still sees mem_ready=0 is abandoned.
// mem_err then pulses for that one cycle and the FSM returns to FETCH.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   opcode       instr[31:26] from the instruction register
//   funct        instr[5:0] from the instruction register
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   mem_we       write qualifier for mem_req
//   iord         memory address select: 0 = PC, 1 = ALU-out register
//   ir_write     load instruction register
//   pc_en        PC load enable = pc_write | (branch & zero)
//   pc_src       00 ALU result, 01 ALU-out register, 10 jump address
//   reg_dst      0 = rt, 1 = rd
//   mem_to_reg   0 = ALU-out register, 1 = memory data register
//   reg_write    register file write enable
//   alu_src_a    0 = PC, 1 = rs
//   alu_src_b    00 rt, 01 constant 4, 10 sign-extended imm, 11 imm<<2
//   alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal      unsupported opcode/funct pulse
//   mem_err      memory timeout pulse
//   state        current FSM state (debug)

module mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          pc_write;
    logic          branch;
    logic          timeout_hit;

    // Only meaningful inside a requesting state: the access has used up its
    // wait budget and memory is still not ready.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == TMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RST;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        pc_src      = 2'b00;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        wait_cnt_d  = '0;

        case (state_q)
            S_RST: begin
                alu_control = 3'b000;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                // ALU computes PC+4 every fetch cycle; the PC and IR only
                // load in the ready cycle so each instruction bumps PC once.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into the ALU-out register.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    FN_ADD:  alu_control = 3'b010;
                    FN_SUB:  alu_control = 3'b110;
                    FN_AND:  alu_control = 3'b000;
                    FN_OR:   alu_control = 3'b001;
                    FN_SLT:  alu_control = 3'b111;
                    default: begin
                        alu_control = 3'b010;
                        illegal     = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // Subtract rs-rt; zero feeds pc_en in this same cycle.
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                branch      = 1'b1;
                pc_src      = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Counter is zero on entry to every requesting state because it is
        // cleared whenever an access ends (ready, abort) or no request is up.
        if (mem_req && !mem_ready && !timeout_hit && (MEM_TIMEOUT != 0)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//
// Directed bench for mc_controller built with MEM_TIMEOUT=4. Inputs change
// on the falling clock edge; outputs are compared 1 time unit later, well away
// from the rising edge. All observed outputs are packed into one word and
// compared against a word built from the per-state output table below, with
// the input-dependent bits (ready, zero, illegal, timeout) set by each test.

module tb_mc_controller;

    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_ADDI_EX = 4'd9;
    localparam logic [3:0] S_ADDI_WB = 4'd10;
    localparam logic [3:0] S_BRANCH  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       irw;
        logic       pcen;
        logic [1:0] pcs;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aluc;
        logic       ill;
        logic       merr;
    } ctl_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal, mem_err;
    logic [3:0] state;

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .state       (state)
    );

    ctl_t obs;
    ctl_t e;
    assign obs = {state, mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
                  illegal, mem_err};

    int total = 0;
    int bad   = 0;

    // Output table with ready/zero/illegal/timeout-dependent bits left at 0.
    function automatic ctl_t spec_out(input logic [3:0] st);
        ctl_t c;
        c      = '0;
        c.st   = st;
        c.aluc = 3'b010;
        case (st)
            S_RST:     c.aluc = 3'b000;
            S_FETCH:   begin c.req = 1'b1; c.asb = 2'b01; end
            S_DECODE:  c.asb = 2'b11;
            S_MEMADR:  begin c.asa = 1'b1; c.asb = 2'b10; end
            S_MEMRD:   begin c.req = 1'b1; c.iord = 1'b1; end
            S_MEMWB:   begin c.m2r = 1'b1; c.rw = 1'b1; end
            S_MEMWR:   begin c.req = 1'b1; c.we = 1'b1; c.iord = 1'b1; end
            S_EXEC:    c.asa = 1'b1;
            S_ALUWB:   begin c.rdst = 1'b1; c.rw = 1'b1; end
            S_ADDI_EX: begin c.asa = 1'b1; c.asb = 2'b10; end
            S_ADDI_WB: c.rw = 1'b1;
            S_BRANCH:  begin c.asa = 1'b1; c.aluc = 3'b110; c.pcs = 2'b01; end
            S_JUMP:    begin c.pcs = 2'b10; c.pcen = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    // Zero-wait fetch; returns on the falling edge with the DUT in DECODE.
    task automatic fetch_insn(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        e = '0;
        total++; if (obs !== e) begin bad++; $display("FAIL por got=%h want=%h", obs, e); end
        repeat (2) @(negedge clk);
        total++; if (obs !== e) begin bad++; $display("FAIL por_held got=%h want=%h", obs, e); end
        rst = 1'b1;
        #1;
        e = spec_out(S_RST);
        total++; if (obs !== e) begin bad++; $display("FAIL rst_release got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL first_fetch got=%h want=%h", obs, e); end
    endtask

    task automatic test_add();
        int pc_cnt;
        pc_cnt = 0;
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        #1;
        e = spec_out(S_FETCH); e.irw = 1'b1; e.pcen = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL add_fetch got=%h want=%h", obs, e); end
        pc_cnt += int'(pc_en);
        @(negedge clk); mem_ready = 1'b0; #1;
        e = spec_out(S_DECODE);
        total++; if (obs !== e) begin bad++; $display("FAIL add_decode got=%h want=%h", obs, e); end
        pc_cnt += int'(pc_en);
        @(negedge clk); #1;
        e = spec_out(S_EXEC); e.aluc = 3'b010;
        total++; if (obs !== e) begin bad++; $display("FAIL add_exec got=%h want=%h", obs, e); end
        pc_cnt += int'(pc_en);
        @(negedge clk); #1;
        e = spec_out(S_ALUWB);
        total++; if (obs !== e) begin bad++; $display("FAIL add_aluwb got=%h want=%h", obs, e); end
        pc_cnt += int'(pc_en);
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL add_ret got=%h want=%h", obs, e); end
        total++; if (pc_cnt !== 1) begin bad++; $display("FAIL add_pc_en_count got=%0d want=1", pc_cnt); end
    endtask

    task automatic test_lw_wait();
        int req_cnt;
        req_cnt = 0;
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        e = spec_out(S_FETCH); e.irw = 1'b1; e.pcen = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL lw_fetch got=%h want=%h", obs, e); end
        req_cnt += int'(mem_req);
        // mem_ready high in non-requesting states must be ignored.
        @(negedge clk); #1;
        e = spec_out(S_DECODE);
        total++; if (obs !== e) begin bad++; $display("FAIL lw_decode got=%h want=%h", obs, e); end
        req_cnt += int'(mem_req);
        @(negedge clk); #1;
        e = spec_out(S_MEMADR);
        total++; if (obs !== e) begin bad++; $display("FAIL lw_memadr got=%h want=%h", obs, e); end
        req_cnt += int'(mem_req);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            e = spec_out(S_MEMRD);
            total++; if (obs !== e) begin bad++; $display("FAIL lw_memrd%0d got=%h want=%h", i, obs, e); end
            req_cnt += int'(mem_req);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        e = spec_out(S_MEMWB);
        total++; if (obs !== e) begin bad++; $display("FAIL lw_memwb got=%h want=%h", obs, e); end
        req_cnt += int'(mem_req);
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL lw_ret got=%h want=%h", obs, e); end
        total++; if (req_cnt !== 5) begin bad++; $display("FAIL lw_req_cycles got=%0d want=5", req_cnt); end
    endtask

    task automatic test_rtype_ops();
        logic [5:0] fns  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alus [4] = '{3'b110,    3'b000,    3'b001,    3'b111};
        for (int i = 0; i < 4; i++) begin
            fetch_insn(6'b000000, fns[i]);
            @(negedge clk); #1;
            e = spec_out(S_EXEC); e.aluc = alus[i];
            total++; if (obs !== e) begin bad++; $display("FAIL rtype_exec%0d got=%h want=%h", i, obs, e); end
            @(negedge clk); #1;
            e = spec_out(S_ALUWB);
            total++; if (obs !== e) begin bad++; $display("FAIL rtype_wb%0d got=%h want=%h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_addi_jump();
        fetch_insn(6'b001000, 6'b000000);
        @(negedge clk); #1;
        e = spec_out(S_ADDI_EX);
        total++; if (obs !== e) begin bad++; $display("FAIL addi_ex got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_ADDI_WB);
        total++; if (obs !== e) begin bad++; $display("FAIL addi_wb got=%h want=%h", obs, e); end
        @(negedge clk);
        fetch_insn(6'b000010, 6'b000000);
        @(negedge clk); #1;
        e = spec_out(S_JUMP);
        total++; if (obs !== e) begin bad++; $display("FAIL jump got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL jump_ret got=%h want=%h", obs, e); end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            fetch_insn(6'b000100, 6'b000000);
            zero = z[0];
            @(negedge clk); #1;
            e = spec_out(S_BRANCH); e.pcen = z[0];
            total++; if (obs !== e) begin bad++; $display("FAIL beq_z%0d got=%h want=%h", z, obs, e); end
            // pc_en follows zero combinationally within the cycle.
            zero = ~z[0];
            #1;
            e = spec_out(S_BRANCH); e.pcen = ~z[0];
            total++; if (obs !== e) begin bad++; $display("FAIL beq_flip%0d got=%h want=%h", z, obs, e); end
            @(negedge clk); zero = 1'b0; #1;
            e = spec_out(S_FETCH);
            total++; if (obs !== e) begin bad++; $display("FAIL beq_ret%0d got=%h want=%h", z, obs, e); end
        end
    endtask

    task automatic test_illegal();
        fetch_insn(6'b111111, 6'b000000);
        #1;
        e = spec_out(S_DECODE); e.ill = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL ill_op got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL ill_op_ret got=%h want=%h", obs, e); end
        fetch_insn(6'b000000, 6'b111111);
        @(negedge clk); #1;
        e = spec_out(S_EXEC); e.ill = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL ill_fn got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL ill_fn_ret got=%h want=%h", obs, e); end
    endtask

    task automatic test_timeout();
        fetch_insn(6'b101011, 6'b000000);
        @(negedge clk);
        @(negedge clk);
        // Four tolerated wait cycles, abort on the fifth still-not-ready cycle.
        for (int i = 0; i < 4; i++) begin
            #1;
            e = spec_out(S_MEMWR);
            total++; if (obs !== e) begin bad++; $display("FAIL sw_wait%0d got=%h want=%h", i, obs, e); end
            @(negedge clk);
        end
        #1;
        e = spec_out(S_MEMWR); e.merr = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL sw_timeout got=%h want=%h", obs, e); end
        @(negedge clk);
        // Back in FETCH with ready low: the same budget applies to a fetch.
        for (int i = 0; i < 4; i++) begin
            #1;
            e = spec_out(S_FETCH);
            total++; if (obs !== e) begin bad++; $display("FAIL fetch_wait%0d got=%h want=%h", i, obs, e); end
            @(negedge clk);
        end
        #1;
        e = spec_out(S_FETCH); e.merr = 1'b1;
        total++; if (obs !== e) begin bad++; $display("FAIL fetch_timeout got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL fetch_refetch got=%h want=%h", obs, e); end
    endtask

    task automatic test_reset_mid_access();
        fetch_insn(6'b100011, 6'b000000);
        @(negedge clk);
        @(negedge clk); #1;
        e = spec_out(S_MEMRD);
        total++; if (obs !== e) begin bad++; $display("FAIL mid_memrd got=%h want=%h", obs, e); end
        #1; rst = 1'b0; #1;
        e = '0;
        total++; if (obs !== e) begin bad++; $display("FAIL mid_rst_async got=%h want=%h", obs, e); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        e = spec_out(S_RST);
        total++; if (obs !== e) begin bad++; $display("FAIL mid_rst_release got=%h want=%h", obs, e); end
        @(negedge clk); #1;
        e = spec_out(S_FETCH);
        total++; if (obs !== e) begin bad++; $display("FAIL mid_rst_fetch got=%h want=%h", obs, e); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_rtype_ops();
        test_addi_jump();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
